// File: rtl/dmem_pkg.sv
// Shared encodings for the data-memory responder: access sizes and FSM states.
package dmem_pkg;

    typedef enum logic [1:0] {
        MEM_BYTE     = 2'b00,
        MEM_HALF     = 2'b01,
        MEM_WORD     = 2'b10,
        MEM_WORD_ALT = 2'b11
    } mem_size_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_RESP = 2'b10
    } state_e;

    // Both upper encodings behave as a full-word access.
    function automatic logic is_word(input logic [1:0] size);
        return size[1];
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Store-lane alignment: byte enables, lane-replicated write data and misalignment flag.
// Fault detection is built only when DMEM_MISALIGN_CHECK_EN is defined.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [1:0]  mem_size,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    output logic [3:0]  byte_en,
    output logic [31:0] lane_data,
    output logic        misaligned
);

    logic [1:0] eff_lo;

    always_comb begin
        eff_lo     = addr_lo;
        misaligned = 1'b0;
`ifdef DMEM_MISALIGN_CHECK_EN
        if (mem_size == MEM_HALF)
            misaligned = addr_lo[0];
        else if (is_word(mem_size))
            misaligned = (addr_lo != 2'b00);
`else
        // Without fault checking, low address bits are simply forced to alignment.
        if (mem_size == MEM_HALF)
            eff_lo = {addr_lo[1], 1'b0};
        else if (is_word(mem_size))
            eff_lo = 2'b00;
`endif
    end

    always_comb begin
        byte_en   = 4'b1111;
        lane_data = wdata;
        case (mem_size)
            MEM_BYTE: begin
                byte_en   = 4'b0001 << eff_lo;
                lane_data = {4{wdata[7:0]}};
            end
            MEM_HALF: begin
                byte_en   = eff_lo[1] ? 4'b1100 : 4'b0011;
                lane_data = {2{wdata[15:0]}};
            end
            default: begin
                byte_en   = 4'b1111;
                lane_data = wdata;
            end
        endcase
        if (misaligned)
            byte_en = 4'b0000;
    end

endmodule

// File: rtl/dmem_responder.sv
// MEM-stage data memory with fixed wait states, store lane masking and pipeline stall.
// Define DMEM_MISALIGN_CHECK_EN to fault misaligned half/word accesses instead of aligning them.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int WAIT_CYCLES = 2,
    parameter int ADDR_W      = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_req,
    input  logic        i_we,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    input  logic [1:0]  i_memSize,
    output logic        o_busy,
    output logic        o_rvalid,
    output logic [31:0] o_rdata,
    output logic        o_misaligned
);

    localparam int         DEPTH     = 2 ** (ADDR_W - 2);
    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    state_e              state;
    state_e              state_next;
    logic [3:0]          cnt;
    logic [3:0]          cnt_next;
    logic                accept;
    logic                do_access;

    logic                req_we;
    logic [ADDR_W-1:0]   req_addr;
    logic [31:0]         req_wdata;
    logic [1:0]          req_size;

    logic [3:0]          byte_en;
    logic [31:0]         lane_data;
    logic                misaligned;
    logic [ADDR_W-3:0]   word_idx;

    logic [31:0]         mem [DEPTH];

    // Upper address bits alias onto the decoded range.
    logic                unused_addr_bits;
    assign unused_addr_bits = ^i_addr[31:ADDR_W];

    assign word_idx = req_addr[ADDR_W-1:2];

    dmem_lane_align u_align (
        .mem_size   (req_size),
        .addr_lo    (req_addr[1:0]),
        .wdata      (req_wdata),
        .byte_en    (byte_en),
        .lane_data  (lane_data),
        .misaligned (misaligned)
    );

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        accept     = 1'b0;
        do_access  = 1'b0;
        case (state)
            ST_IDLE, ST_RESP: begin
                if (i_req) begin
                    accept     = 1'b1;
                    cnt_next   = WAIT_INIT;
                    state_next = ST_WAIT;
                end else begin
                    state_next = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt != 4'd0) begin
                    cnt_next = cnt - 4'd1;
                end else begin
                    do_access  = 1'b1;
                    state_next = ST_RESP;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign o_busy = !reset &&
                    ((state == ST_WAIT) ||
                     (i_req && ((state == ST_IDLE) || (state == ST_RESP))));

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            req_we    <= 1'b0;
            req_addr  <= '0;
            req_wdata <= '0;
            req_size  <= MEM_BYTE;
        end else if (accept) begin
            req_we    <= i_we;
            req_addr  <= i_addr[ADDR_W-1:0];
            req_wdata <= i_wdata;
            req_size  <= i_memSize;
        end
    end

    // Stores and faulted accesses report zero read data.
    always_ff @(posedge clk) begin
        if (reset) begin
            o_rvalid     <= 1'b0;
            o_rdata      <= 32'd0;
            o_misaligned <= 1'b0;
        end else begin
            o_rvalid     <= do_access;
            o_misaligned <= do_access && misaligned;
            if (do_access)
                o_rdata <= (!req_we && !misaligned) ? mem[word_idx] : 32'd0;
        end
    end

    // No reset on the array; a reset edge suppresses any pending write.
    always_ff @(posedge clk) begin
        if (do_access && req_we && !reset) begin
            for (int lane = 0; lane < 4; lane++) begin
                if (byte_en[lane])
                    mem[word_idx][lane*8 +: 8] <= lane_data[lane*8 +: 8];
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized self-checking bench for dmem_responder against a byte-level memory model.
module tb_dmem_responder;

    localparam int WAIT = 2;
    localparam int AW   = 16;
`ifdef DMEM_MISALIGN_CHECK_EN
    localparam bit CHECK_EN = 1'b1;
`else
    localparam bit CHECK_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        i_req;
    logic        i_we;
    logic [31:0] i_addr;
    logic [31:0] i_wdata;
    logic [1:0]  i_memSize;
    logic        o_busy;
    logic        o_rvalid;
    logic [31:0] o_rdata;
    logic        o_misaligned;

    int total = 0;
    int bad   = 0;

    logic [7:0] ref_mem [int];

    dmem_responder #(.WAIT_CYCLES(WAIT), .ADDR_W(AW)) dut (
        .clk          (clk),
        .reset        (reset),
        .i_req        (i_req),
        .i_we         (i_we),
        .i_addr       (i_addr),
        .i_wdata      (i_wdata),
        .i_memSize    (i_memSize),
        .o_busy       (o_busy),
        .o_rvalid     (o_rvalid),
        .o_rdata      (o_rdata),
        .o_misaligned (o_misaligned)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic int numBytes(input logic [1:0] size);
        if (size == 2'd0) return 1;
        if (size == 2'd1) return 2;
        return 4;
    endfunction

    function automatic bit refMisaligned(input logic [1:0] size, input logic [31:0] addr);
        int a = int'(addr % 32'd4);
        if (!CHECK_EN) return 1'b0;
        if (size == 2'd1) return (a % 2) != 0;
        if (size >= 2'd2) return a != 0;
        return 1'b0;
    endfunction

    // Model: apply the access to the byte array, return what the response should carry.
    task automatic refAccess(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [1:0] size, output logic [31:0] exp_data,
                             output logic exp_mis, output bit known);
        int a = int'(addr % (32'd1 << AW));
        int n = numBytes(size);
        int base;
        exp_data = 32'd0;
        exp_mis  = refMisaligned(size, addr);
        known    = 1'b1;
        if (!CHECK_EN)
            a = a - (a % n);
        if (we) begin
            if (!exp_mis)
                for (int b = 0; b < n; b++)
                    ref_mem[a + b] = 8'((wdata >> (8 * b)) & 32'hFF);
        end else if (!exp_mis) begin
            base = a - (a % 4);
            for (int b = 0; b < 4; b++) begin
                if (!ref_mem.exists(base + b)) known = 1'b0;
                else exp_data = exp_data | (32'(ref_mem[base + b]) << (8 * b));
            end
        end
    endtask

    task automatic applyStimulus(input string tag, input logic we, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [1:0] size);
        logic [31:0] exp_data;
        logic        exp_mis;
        bit          known;
        int          busy_cnt = 0;
        int          lat = -1;
        refAccess(we, addr, wdata, size, exp_data, exp_mis, known);
        @(negedge clk);
        i_we = we; i_addr = addr; i_wdata = wdata; i_memSize = size; i_req = 1'b1;
        #1;
        if (o_busy) busy_cnt++;
        @(posedge clk); #1;
        i_req = 1'b0;
        for (int n = 0; n <= 40; n++) begin
            if (o_rvalid) begin
                lat = n;
                break;
            end
            if (o_busy) busy_cnt++;
            @(posedge clk); #1;
        end
        checkOutput({tag, "_latency"}, 32'(lat), 32'(WAIT + 1));
        checkOutput({tag, "_busy"}, 32'(busy_cnt), 32'(WAIT + 2));
        checkOutput({tag, "_mis"}, {31'd0, o_misaligned}, {31'd0, exp_mis});
        if (known)
            checkOutput({tag, "_rdata"}, o_rdata, exp_data);
        @(posedge clk); #1;
        checkOutput({tag, "_rvalid_pulse"}, {31'd0, o_rvalid}, 32'd0);
    endtask

    task automatic backToBack();
        logic [31:0] addrs [3];
        logic [31:0] exps  [3];
        logic        mis;
        bit          known;
        int          k = 0;
        int          gap = 0;
        addrs[0] = 32'h10; addrs[1] = 32'h20; addrs[2] = 32'h4;
        for (int i = 0; i < 3; i++)
            refAccess(1'b0, addrs[i], 32'd0, 2'd2, exps[i], mis, known);
        @(negedge clk);
        i_we = 1'b0; i_memSize = 2'd2; i_addr = addrs[0]; i_req = 1'b1;
        @(posedge clk); #1;
        for (int n = 0; n < 200 && k < 3; n++) begin
            if (o_rvalid) begin
                checkOutput($sformatf("b2b_rdata%0d", k), o_rdata, exps[k]);
                checkOutput($sformatf("b2b_busy%0d", k), {31'd0, o_busy}, 32'd1);
                if (k > 0)
                    checkOutput($sformatf("b2b_gap%0d", k), 32'(gap), 32'(WAIT + 1));
                if (k < 2) i_addr = addrs[k + 1];
                else       i_req = 1'b0;
                k++;
                gap = 0;
            end else begin
                gap++;
            end
            @(posedge clk); #1;
        end
        checkOutput("b2b_count", 32'(k), 32'd3);
    endtask

    task automatic resetMidStore();
        @(negedge clk);
        i_we = 1'b1; i_addr = 32'h30; i_wdata = 32'h55; i_memSize = 2'd0; i_req = 1'b1;
        @(posedge clk); #1;
        i_req = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        checkOutput("rst_mid_busy", {31'd0, o_busy}, 32'd0);
        checkOutput("rst_mid_rvalid", {31'd0, o_rvalid}, 32'd0);
        checkOutput("rst_mid_rdata", o_rdata, 32'd0);
        checkOutput("rst_mid_mis", {31'd0, o_misaligned}, 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        applyStimulus("rst_reload", 1'b0, 32'h30, 32'd0, 2'd2);
    endtask

    initial begin
        reset = 1'b1; i_req = 1'b1; i_we = 1'b0; i_addr = 32'd0; i_wdata = 32'd0; i_memSize = 2'd2;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_busy", {31'd0, o_busy}, 32'd0);
        checkOutput("reset_rvalid", {31'd0, o_rvalid}, 32'd0);
        checkOutput("reset_rdata", o_rdata, 32'd0);
        checkOutput("reset_mis", {31'd0, o_misaligned}, 32'd0);
        @(negedge clk);
        reset = 1'b0; i_req = 1'b0;

        for (int w = 0; w < 16; w++)
            applyStimulus("init", 1'b1, 32'(w * 4), $urandom, 2'd2);

        applyStimulus("word_st", 1'b1, 32'h10, 32'hDEADBEEF, 2'd2);
        applyStimulus("word_ld", 1'b0, 32'h10, 32'd0, 2'd2);
        applyStimulus("zero_st", 1'b1, 32'h20, 32'h0, 2'd2);
        applyStimulus("byte_st", 1'b1, 32'h23, 32'h000000AB, 2'd0);
        applyStimulus("byte_ld", 1'b0, 32'h20, 32'd0, 2'd2);
        applyStimulus("half_st", 1'b1, 32'h22, 32'h00001234, 2'd1);
        applyStimulus("half_ld", 1'b0, 32'h20, 32'd0, 2'd2);
        applyStimulus("mis_st", 1'b1, 32'h21, 32'hFFFFFFFF, 2'd2);
        applyStimulus("mis_ld", 1'b0, 32'h20, 32'd0, 2'd2);
        applyStimulus("mis_half_ld", 1'b0, 32'h13, 32'd0, 2'd1);
        applyStimulus("alias_st", 1'b1, 32'h0001_0004, 32'h1, 2'd2);
        applyStimulus("alias_ld", 1'b0, 32'h4, 32'd0, 2'd2);

        backToBack();
        resetMidStore();

        for (int t = 0; t < 60; t++)
            applyStimulus($sformatf("rand%0d", t), 1'($urandom_range(0, 1)),
                          ($urandom & 32'hFFFF_0000) | 32'($urandom_range(0, 63)),
                          $urandom, 2'($urandom_range(0, 3)));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
